// File: rtl/mem_loader.sv
// Bus initiator that bulk-loads a valid/ready word stream into data RAM and reports
// the checksum (or an error code) to the segment register. Optional read-back verify: LOADER_VERIFY_EN.
module mem_loader #(
  parameter int unsigned        ADDR_W   = 15,
  parameter logic [ADDR_W-1:0]  SEG_ADDR = 15'h4000,
  parameter logic [15:0]        ERR_CODE = 16'hEEEE,
  localparam int unsigned       DATA_W   = 16,
  localparam int unsigned       LEN_W    = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_in,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_wEna,
  input  logic [DATA_W-1:0] m_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] sum
);

  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, CHECK, SEG, DONE} stateT;

  stateT             state, stateNext;
  logic [LEN_W-1:0]  lenQ, lenNext;
  logic [LEN_W-1:0]  ptr, ptrNext, ptrInc;
  logic [DATA_W-1:0] sumNext;
  logic [DATA_W-1:0] mInNext;
  logic [ADDR_W-1:0] mAddrNext;
  logic              mWEnaNext;
  logic              sReadyNext;
  logic              busyNext;
  logic              doneNext;
  logic              handshake;

`ifdef LOADER_VERIFY_EN
  logic [LEN_W-1:0]  rdPtr, rdPtrNext;
  logic [DATA_W-1:0] chk, chkNext;
  logic              addrVld, addrVldNext;
  logic              dataVld;
  logic              errNext;
`else
  logic              unusedBits;
  assign unusedBits = ^m_out;
  assign err        = 1'b0;
`endif

  assign handshake = s_ready & s_valid;
  assign ptrInc    = ptr + LEN_W'(1);

  // State and registered bus/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lenQ    <= '0;
      ptr     <= '0;
      sum     <= '0;
      m_in    <= '0;
      m_addr  <= '0;
      m_wEna  <= 1'b0;
      s_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= stateNext;
      lenQ    <= lenNext;
      ptr     <= ptrNext;
      sum     <= sumNext;
      m_in    <= mInNext;
      m_addr  <= mAddrNext;
      m_wEna  <= mWEnaNext;
      s_ready <= sReadyNext;
      busy    <= busyNext;
      done    <= doneNext;
    end
  end

`ifdef LOADER_VERIFY_EN
  // Read-back pipeline: issue -> address on bus -> data on m_out
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr   <= '0;
      chk     <= '0;
      addrVld <= 1'b0;
      dataVld <= 1'b0;
      err     <= 1'b0;
    end else begin
      rdPtr   <= rdPtrNext;
      chk     <= chkNext;
      addrVld <= addrVldNext;
      dataVld <= addrVld;
      err     <= errNext;
    end
  end
`endif

  // Next state and next registered outputs
  always_comb begin
    stateNext = state;
    lenNext   = lenQ;
    ptrNext   = ptr;
    sumNext   = sum;
    mInNext   = m_in;
    mAddrNext = m_addr;
    mWEnaNext = 1'b0;
    doneNext  = 1'b0;
`ifdef LOADER_VERIFY_EN
    rdPtrNext   = rdPtr;
    chkNext     = dataVld ? chk + m_out : chk;
    addrVldNext = (state == VERIFY) && (rdPtr != lenQ);
    errNext     = err;
`endif

    case (state)
      IDLE: begin
        mAddrNext = '0;
        mInNext   = '0;
        if (start) begin
          lenNext   = len;
          ptrNext   = '0;
          sumNext   = '0;
`ifdef LOADER_VERIFY_EN
          rdPtrNext = '0;
          chkNext   = '0;
          errNext   = 1'b0;
`endif
          stateNext = (len == '0) ? SEG : LOAD;
        end
      end

      LOAD: begin
        if (handshake) begin
          mAddrNext = ADDR_W'(ptr);
          mInNext   = s_data;
          mWEnaNext = 1'b1;
          sumNext   = sum + s_data;
          ptrNext   = ptrInc;
          if (ptrInc == lenQ) begin
`ifdef LOADER_VERIFY_EN
            stateNext = VERIFY;
`else
            stateNext = SEG;
`endif
          end
        end
      end

`ifdef LOADER_VERIFY_EN
      VERIFY: begin
        if (rdPtr != lenQ) begin
          mAddrNext = ADDR_W'(rdPtr);
          rdPtrNext = rdPtr + LEN_W'(1);
        end
        // Leave once the final read's data has been folded into chk
        if ((rdPtr == lenQ) && !addrVld && dataVld) begin
          stateNext = CHECK;
        end
      end

      CHECK: begin
        mAddrNext = SEG_ADDR;
        mWEnaNext = 1'b1;
        if (chk == sum) begin
          mInNext = sum;
        end else begin
          mInNext = ERR_CODE;
          errNext = 1'b1;
        end
        stateNext = DONE;
      end
`endif

      SEG: begin
        mAddrNext = SEG_ADDR;
        mInNext   = sum;
        mWEnaNext = 1'b1;
        stateNext = DONE;
      end

      DONE: begin
        mAddrNext = '0;
        doneNext  = 1'b1;
        stateNext = IDLE;
      end

      default: stateNext = IDLE;
    endcase

    sReadyNext = (stateNext == LOAD);
    busyNext   = (stateNext != IDLE) || (state == DONE);
  end

endmodule
